hv_adc_conv_ctrl: RTL and testbench

HV_ADC_CONV_CTRL -- requirements
Module: hv_adc_conv_ctrl

---
 rtl/hv_adc_conv_ctrl.sv | 147 ++++++++++++++
 tb/tb_hv_adc_conv_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hv_adc_conv_ctrl.sv
// Schedules paired ADC1/ADC2 conversions on a period tick and runs a 4-phase
// soc/rdy handshake per channel with the analog macro, with timeout and overrun flags.
module hv_adc_conv_ctrl #(
  parameter int ADC_DW  = 10,
  parameter int PRD_DW  = 16,
  parameter int TMO_CYC = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_adc_en,
  input  logic [PRD_DW-1:0] i_period,
  output logic              o_dgt_ang_adc_soc,
  output logic              o_dgt_ang_adc_ch,
  input  logic              i_ang_dgt_adc_rdy,
  input  logic [ADC_DW-1:0] i_ang_dgt_adc_data,
  output logic [ADC_DW-1:0] o_adc1_data,
  output logic              o_adc1_vld,
  output logic [ADC_DW-1:0] o_adc2_data,
  output logic              o_adc2_vld,
  output logic              o_tmo_err,
  output logic              o_ovr_err
);

  localparam int TW = $clog2(TMO_CYC + 1);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t            state;
  logic              rdy_meta;
  logic              sync_rdy;
  logic              sync_rdy_q;
  logic [PRD_DW-1:0] prd_cnt;
  logic [PRD_DW-1:0] prd_last;
  logic              tick;
  logic [TW-1:0]     tmo_cnt;
  logic              tmo_hit;
  logic              rdy_low;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdy_meta   <= 1'b0;
      sync_rdy   <= 1'b0;
      sync_rdy_q <= 1'b0;
    end else begin
      rdy_meta   <= i_ang_dgt_adc_rdy;
      sync_rdy   <= rdy_meta;
      sync_rdy_q <= sync_rdy;
    end
  end

  // Periods of 0 and 1 behave as 2, so the last count is never below 1.
  assign prd_last = (~|i_period[PRD_DW-1:1]) ? PRD_DW'(1) : i_period - PRD_DW'(1);
  assign tick     = i_adc_en && (prd_cnt == prd_last);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prd_cnt <= '0;
    end else if (!i_adc_en || tick) begin
      prd_cnt <= '0;
    end else begin
      prd_cnt <= prd_cnt + PRD_DW'(1);
    end
  end

  assign tmo_hit = (tmo_cnt == TW'(TMO_CYC - 1));
  // Release needs two consecutive low samples so a short rdy glitch cannot advance DROP.
  assign rdy_low = !sync_rdy && !sync_rdy_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state             <= IDLE;
      o_dgt_ang_adc_soc <= 1'b0;
      o_dgt_ang_adc_ch  <= 1'b0;
      tmo_cnt           <= '0;
      o_adc1_data       <= '0;
      o_adc1_vld        <= 1'b0;
      o_adc2_data       <= '0;
      o_adc2_vld        <= 1'b0;
      o_tmo_err         <= 1'b0;
      o_ovr_err         <= 1'b0;
    end else begin
      o_adc1_vld <= 1'b0;
      o_adc2_vld <= 1'b0;
      o_tmo_err  <= 1'b0;
      o_ovr_err  <= tick && ((state != IDLE) || sync_rdy);
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (tick && !sync_rdy) begin
            state             <= REQ;
            o_dgt_ang_adc_ch  <= 1'b0;
            o_dgt_ang_adc_soc <= 1'b1;
          end
        end
        REQ: begin
          if (tmo_hit) begin
            state             <= IDLE;
            o_dgt_ang_adc_soc <= 1'b0;
            o_dgt_ang_adc_ch  <= 1'b0;
            o_tmo_err         <= 1'b1;
            tmo_cnt           <= '0;
          end else if (sync_rdy) begin
            state             <= DROP;
            o_dgt_ang_adc_soc <= 1'b0;
            tmo_cnt           <= '0;
            if (!o_dgt_ang_adc_ch) begin
              o_adc1_data <= i_ang_dgt_adc_data;
              o_adc1_vld  <= 1'b1;
            end else begin
              o_adc2_data <= i_ang_dgt_adc_data;
              o_adc2_vld  <= 1'b1;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        DROP: begin
          if (tmo_hit) begin
            state            <= IDLE;
            o_dgt_ang_adc_ch <= 1'b0;
            o_tmo_err        <= 1'b1;
            tmo_cnt          <= '0;
          end else if (rdy_low) begin
            tmo_cnt <= '0;
            if (!o_dgt_ang_adc_ch) begin
              state             <= REQ;
              o_dgt_ang_adc_ch  <= 1'b1;
              o_dgt_ang_adc_soc <= 1'b1;
            end else begin
              state            <= IDLE;
              o_dgt_ang_adc_ch <= 1'b0;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        default: begin
          state             <= IDLE;
          o_dgt_ang_adc_soc <= 1'b0;
          o_dgt_ang_adc_ch  <= 1'b0;
          tmo_cnt           <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hv_adc_conv_ctrl.sv
// Bench for hv_adc_conv_ctrl: behavioural analog macro, tick/transaction scoreboard,
// a table of scheduling scenarios and directed timeout/disable/glitch/reset sequences.
module tb_hv_adc_conv_ctrl;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        en     = 1'b0;
  logic [15:0] period = 16'd100;
  logic        soc;
  logic        ch;
  logic        rdy    = 1'b0;
  logic [9:0]  adata  = '0;
  logic [9:0]  a1;
  logic [9:0]  a2;
  logic        v1;
  logic        v2;
  logic        tmo;
  logic        ovr;

  always #5 clk = ~clk;

  hv_adc_conv_ctrl #(.ADC_DW(10), .PRD_DW(16), .TMO_CYC(255)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_adc_en           (en),
    .i_period           (period),
    .o_dgt_ang_adc_soc  (soc),
    .o_dgt_ang_adc_ch   (ch),
    .i_ang_dgt_adc_rdy  (rdy),
    .i_ang_dgt_adc_data (adata),
    .o_adc1_data        (a1),
    .o_adc1_vld         (v1),
    .o_adc2_data        (a2),
    .o_adc2_vld         (v2),
    .o_tmo_err          (tmo),
    .o_ovr_err          (ovr)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Analog macro model
  int         an_rise  = 3;
  int         an_fall  = 3;
  bit         an_never = 1'b0;
  bit         an_hold  = 1'b0;
  logic [9:0] an_d1    = 10'h155;
  logic [9:0] an_d2    = 10'h2AA;
  logic [9:0] pres [2];
  int         hi_cnt   = 0;
  int         lo_cnt   = 0;

  initial forever begin
    @(negedge clk);
    if (soc) begin
      lo_cnt = 0;
      hi_cnt++;
      if (!an_never && !rdy && hi_cnt == an_rise) begin
        adata    = ch ? an_d2 : an_d1;
        pres[ch] = adata;
        rdy      = 1'b1;
      end
    end else begin
      hi_cnt = 0;
      if (rdy && !an_hold) begin
        lo_cnt++;
        if (lo_cnt >= an_fall) begin
          rdy    = 1'b0;
          lo_cnt = 0;
          adata  = 10'($urandom);
        end
      end
    end
  end

  // Scoreboard: ticks every P enabled cycles, each answered by exactly one start or overrun
  int run = 0;
  int mp  = 2;
  bit tick_pend = 1'b0;
  bit soc_prev  = 1'b0;
  bit pend1     = 1'b0;
  bit start;
  int n_v1 = 0, n_v2 = 0, n_tmo = 0, n_ovr = 0, n_start = 0;

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      run       = 0;
      tick_pend = 1'b0;
    end else begin
      mp        = (period < 2) ? 2 : int'(period);
      tick_pend = en && ((run % mp) == mp - 1);
      run       = en ? run + 1 : 0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      start = soc && !soc_prev && !ch;
      if (tick_pend) chk("tick_start_xor_ovr", start ^ ovr, 1);
      else if (start || ovr) chk("start_or_ovr_without_tick", {start, ovr}, 0);
      if (v1) begin
        chk("adc1_data_on_vld", a1, pres[0]);
        n_v1++;
        pend1 = 1'b1;
      end
      if (v2) begin
        chk("adc2_after_adc1", pend1, 1);
        chk("adc2_data_on_vld", a2, pres[1]);
        n_v2++;
        pend1 = 1'b0;
      end
      if (tmo)   n_tmo++;
      if (ovr)   n_ovr++;
      if (start) n_start++;
      soc_prev = soc;
    end else begin
      soc_prev = 1'b0;
    end
  end

  task automatic wait_idle();
    int quiet = 0;
    for (int c = 0; c < 3000 && quiet < 10; c++) begin
      @(negedge clk);
      if (!soc && !rdy) quiet++;
      else quiet = 0;
    end
    chk("idle_reached", quiet >= 10, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_soc"}, soc, 0);
    chk({tag, "_ch"}, ch, 0);
    chk({tag, "_adc1_data"}, a1, 0);
    chk({tag, "_adc2_data"}, a2, 0);
    chk({tag, "_adc1_vld"}, v1, 0);
    chk({tag, "_adc2_vld"}, v2, 0);
    chk({tag, "_tmo"}, tmo, 0);
    chk({tag, "_ovr"}, ovr, 0);
  endtask

  typedef struct {
    int         prd;
    int         rise;
    int         fall;
    logic [9:0] d1;
    logic [9:0] d2;
    int         nseq;
    bit         exp_ovr;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int k, v1_0, v2_0, ovr_0, tmo_0, st_0, bound, p;

    // Busy time per pair is 2*(rise+fall+5) cycles; overrun expected when P fits inside it.
    vecs[0] = '{100, 3,  3,  10'h155, 10'h2AA, 3, 1'b0};
    vecs[1] = '{5,   10, 10, 10'h0F0, 10'h30F, 3, 1'b1};
    vecs[2] = '{0,   1,  1,  10'h001, 10'h3FF, 4, 1'b1};
    vecs[3] = '{1,   2,  5,  10'h200, 10'h1FF, 2, 1'b1};
    vecs[4] = '{60,  7,  2,  10'h3C3, 10'h0A5, 2, 1'b0};
    for (int i = 5; i < 8; i++) begin
      vecs[i].prd     = int'($urandom_range(60, 120));
      vecs[i].rise    = int'($urandom_range(1, 8));
      vecs[i].fall    = int'($urandom_range(1, 8));
      vecs[i].d1      = 10'($urandom);
      vecs[i].d2      = 10'($urandom);
      vecs[i].nseq    = 2;
      vecs[i].exp_ovr = 1'b0;
    end

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Timeout: analog never answers
    an_never = 1'b1;
    period   = 16'd300;
    en       = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!soc && k < 400);
    chk("tmo_first_start_cycles", k, 300);
    k = 1;
    while (soc && k < 400) begin @(negedge clk); if (soc) k++; end
    chk("tmo_soc_high_cycles", k, 255);
    chk("tmo_pulses", n_tmo, 1);
    chk("tmo_no_vld", n_v1 + n_v2, 0);
    chk("tmo_adc1_kept", a1, 0);
    chk("tmo_adc2_kept", a2, 0);
    an_never = 1'b0;
    k = 0;
    while (n_v2 < 1 && k < 600) begin @(negedge clk); k++; end
    chk("tmo_restart_pair", n_v2, 1);
    chk("tmo_restart_adc1", a1, 10'h155);
    chk("tmo_restart_adc2", a2, 10'h2AA);
    en = 1'b0;
    wait_idle();

    // Table of scheduling scenarios
    for (int i = 0; i < 8; i++) begin
      an_rise = vecs[i].rise;
      an_fall = vecs[i].fall;
      an_d1   = vecs[i].d1;
      an_d2   = vecs[i].d2;
      period  = 16'(vecs[i].prd);
      p       = (vecs[i].prd < 2) ? 2 : vecs[i].prd;
      bound   = vecs[i].nseq * (p + 2 * (vecs[i].rise + vecs[i].fall + 5)) * 2 + 500;
      v2_0    = n_v2;
      ovr_0   = n_ovr;
      en      = 1'b1;
      k = 0;
      while ((n_v2 - v2_0) < vecs[i].nseq && k < bound) begin @(negedge clk); k++; end
      en = 1'b0;
      wait_idle();
      chk($sformatf("vec%0d_pairs", i), n_v2 - v2_0, vecs[i].nseq);
      chk($sformatf("vec%0d_adc1", i), a1, vecs[i].d1);
      chk($sformatf("vec%0d_adc2", i), a2, vecs[i].d2);
      chk($sformatf("vec%0d_ovr_seen", i), n_ovr > ovr_0, vecs[i].exp_ovr);
    end

    // Disable while ch0 is being requested: pair completes, nothing new starts
    an_rise = 4; an_fall = 4; an_d1 = 10'h0C3; an_d2 = 10'h13C;
    period  = 16'd50;
    en      = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!soc && k < 100);
    @(negedge clk);
    en   = 1'b0;
    v1_0 = n_v1;
    v2_0 = n_v2;
    k = 0;
    while (n_v2 == v2_0 && k < 200) begin @(negedge clk); k++; end
    chk("dis_adc1_completed", n_v1 - v1_0, 1);
    chk("dis_adc2_completed", n_v2 - v2_0, 1);
    wait_idle();
    st_0 = n_start;
    repeat (200) @(negedge clk);
    chk("dis_no_new_start", n_start - st_0, 0);
    chk("dis_soc_low", soc, 0);
    en = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!soc && k < 100);
    chk("reenable_first_start_cycles", k, 50);
    en = 1'b0;
    wait_idle();

    // Longest period
    an_rise = 2; an_fall = 2;
    period  = 16'hFFFF;
    en      = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!soc && k < 70000);
    chk("max_period_first_start_cycles", k, 65535);
    en = 1'b0;
    wait_idle();

    // rdy glitch in DROP, then reset while rdy is still held high
    an_rise = 3; an_fall = 3; an_d1 = 10'h2D2; an_d2 = 10'h12D;
    an_hold = 1'b1;
    period  = 16'd40;
    v1_0    = n_v1;
    v2_0    = n_v2;
    en      = 1'b1;
    k = 0;
    while (n_v1 == v1_0 && k < 200) begin @(negedge clk); k++; end
    en = 1'b0;
    repeat (3) @(negedge clk);
    rdy = 1'b0;
    @(negedge clk);
    rdy = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_adc1_once", n_v1 - v1_0, 1);
    chk("glitch_no_adc2", n_v2 - v2_0, 0);
    chk("glitch_soc_low", soc, 0);
    chk("glitch_adc1_data", a1, 10'h2D2);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    @(negedge clk);
    period = 16'd4;
    en     = 1'b1;
    rst_n  = 1'b1;
    ovr_0  = n_ovr;
    st_0   = n_start;
    repeat (4) @(negedge clk);
    chk("post_reset_tick_ovr", ovr, 1);
    chk("post_reset_tick_no_soc", soc, 0);
    chk("post_reset_ovr_count", n_ovr - ovr_0, 1);
    chk("post_reset_no_start", n_start - st_0, 0);
    an_hold = 1'b0;
    v2_0    = n_v2;
    k = 0;
    while (n_v2 == v2_0 && k < 300) begin @(negedge clk); k++; end
    en = 1'b0;
    wait_idle();
    chk("post_reset_pair_done", n_v2 - v2_0, 1);
    chk("post_reset_adc1", a1, 10'h2D2);
    chk("post_reset_adc2", a2, 10'h12D);
    chk("tmo_total", n_tmo, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
